// File: rtl/carry_select_adder_pkg.sv
// Shared helpers for the carry-select adder.
package carry_select_adder_pkg;

  // Number of carry-select blocks needed to cover w bits with b-bit blocks.
  function automatic int calc_nblk(input int w, input int b);
    return (w + b - 1) / b;
  endfunction

endpackage

// File: rtl/carry_select_adder_ripple_carry_block.sv
// N-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_block #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] cc;

  assign cc[0] = ci;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]    = a[i] ^ b[i] ^ cc[i];
    assign cc[i+1] = (a[i] & b[i]) | (cc[i] & (a[i] ^ b[i]));
  end

  assign co = cc[N];

endmodule

// File: rtl/carry_select_adder.sv
// Registered carry-select adder: {cout,sum} = a + b + cin, one cycle latency.
// Block 0 ripples from cin; each later block precomputes both carry-in cases
// and the incoming block carry picks one.
module carry_select_adder
  import carry_select_adder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BLOCK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NBLK = calc_nblk(WIDTH, BLOCK);

  // c[k] is the carry into block k; c[NBLK] is the final carry out.
  logic [NBLK:0]    c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign c[0] = cin;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = k * BLOCK;
    // Final block is narrower when BLOCK does not divide WIDTH.
    localparam int BW = ((WIDTH - LO) < BLOCK) ? (WIDTH - LO) : BLOCK;

    if (k == 0) begin : g_first
      logic [BW-1:0] s0;
      logic          co0;

      ripple_carry_block #(.N(BW)) u_rc (
        .a  (a[LO +: BW]),
        .b  (b[LO +: BW]),
        .ci (c[0]),
        .s  (s0),
        .co (co0)
      );

      assign sum_d[LO +: BW] = s0;
      assign c[1]            = co0;
    end else begin : g_sel
      logic [BW-1:0] s_c0, s_c1;
      logic          co_c0, co_c1;

      ripple_carry_block #(.N(BW)) u_rc0 (
        .a  (a[LO +: BW]),
        .b  (b[LO +: BW]),
        .ci (1'b0),
        .s  (s_c0),
        .co (co_c0)
      );

      ripple_carry_block #(.N(BW)) u_rc1 (
        .a  (a[LO +: BW]),
        .b  (b[LO +: BW]),
        .ci (1'b1),
        .s  (s_c1),
        .co (co_c1)
      );

      // Previous block's carry selects both sum bits and carry out.
      assign sum_d[LO +: BW] = c[k] ? s_c1  : s_c0;
      assign c[k+1]          = c[k] ? co_c1 : co_c0;
    end
  end

  assign cout_d = c[NBLK];

  // Output register; reset clears the result and wins over any input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// Self-checking bench: four WIDTH=4 adders (BLOCK=1..4) share inputs, plus a
// WIDTH=16/BLOCK=4 adder; results are checked against plain a+b+cin.
module tb_carry_select_adder;

  logic        clk;
  logic        rst;
  logic [3:0]  a4, b4;
  logic        cin4;
  logic [3:0]  s_w4  [4];
  logic        co_w4 [4];
  logic [15:0] a16, b16;
  logic        cin16;
  logic [15:0] s16;
  logic        co16;

  int n_vec;
  int n_err;

  carry_select_adder #(.WIDTH(4), .BLOCK(1)) u_b1 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .sum(s_w4[0]), .cout(co_w4[0]));
  carry_select_adder #(.WIDTH(4), .BLOCK(2)) u_b2 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .sum(s_w4[1]), .cout(co_w4[1]));
  carry_select_adder #(.WIDTH(4), .BLOCK(3)) u_b3 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .sum(s_w4[2]), .cout(co_w4[2]));
  carry_select_adder #(.WIDTH(4), .BLOCK(4)) u_b4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .sum(s_w4[3]), .cout(co_w4[3]));
  carry_select_adder #(.WIDTH(16), .BLOCK(4)) u_w16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .sum(s16), .cout(co16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs away from the edge, clock it in, settle.
  task automatic step(input logic r, input logic [3:0] av, input logic [3:0] bv, input logic cv,
                      input logic [15:0] aw, input logic [15:0] bw, input logic cw);
    @(negedge clk);
    rst = r; a4 = av; b4 = bv; cin4 = cv; a16 = aw; b16 = bw; cin16 = cw;
    @(posedge clk);
    #1;
  endtask

  // Compare all WIDTH=4 adders against an expected {cout,sum}.
  task automatic chk4(input string name, input logic [4:0] exp);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({co_w4[i], s_w4[i]} !== exp) begin
        n_err++;
        $display("FAIL %s blk=%0d a=%h b=%h cin=%b got=%h want=%h",
                 name, i + 1, a4, b4, cin4, {co_w4[i], s_w4[i]}, exp);
      end
    end
  endtask

  task automatic chk16(input string name, input logic [16:0] exp);
    n_vec++;
    if ({co16, s16} !== exp) begin
      n_err++;
      $display("FAIL %s a=%h b=%h cin=%b got=%h want=%h", name, a16, b16, cin16, {co16, s16}, exp);
    end
  endtask

  function automatic logic [4:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
    int t;
    t = int'(x) + int'(y) + int'(c);
    return t[4:0];
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
    int t;
    t = int'(x) + int'(y) + int'(c);
    return t[16:0];
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      chk4("reset_hold", 5'h00);
      chk16("reset_hold16", 17'h0);
    end
    step(1'b0, 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    chk4("reset_release", 5'h1F);
    chk16("reset_release16", 17'h1FFFF);
  endtask

  task automatic test_directed();
    logic [3:0] ta [5] = '{4'b1001, 4'b0110, 4'b1001, 4'b0110, 4'b0000};
    logic [3:0] tb [5] = '{4'b0110, 4'b0110, 4'b1010, 4'b1001, 4'b0000};
    logic       tc [5] = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1};
    logic [4:0] te [5] = '{5'b01111, 5'b01101, 5'b10011, 5'b10000, 5'b00001};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, ta[i], tb[i], tc[i], 16'h0000, 16'h0000, tc[i]);
      chk4("directed", te[i]);
      // Also compare against the behavioural reference sum.
      chk4("directed_ref", ref4(ta[i], tb[i], tc[i]));
    end
    chk16("zero_plus_cin16", 17'h00001);
  endtask

  task automatic test_exhaustive();
    logic [8:0] v;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      step(1'b0, v[3:0], v[7:4], v[8], 16'h0, 16'h0, 1'b0);
      chk4("exhaustive", ref4(v[3:0], v[7:4], v[8]));
    end
  endtask

  task automatic test_random16();
    logic [15:0] x, y;
    logic        c;
    step(1'b0, 4'h0, 4'h0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    chk16("allones16", 17'h1FFFF);
    step(1'b0, 4'h0, 4'h0, 1'b0, 16'h5555, 16'hAAAA, 1'b1);
    chk16("chain16", 17'h10000);
    for (int i = 0; i < 400; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      c = 1'($urandom_range(0, 1));
      step(1'b0, 4'h0, 4'h0, 1'b0, x, y, c);
      chk16("random16", ref16(x, y, c));
    end
  endtask

  task automatic test_back_to_back();
    // Reset in the middle of a stream: no result survives, and the first
    // edge after release shows the inputs sampled at that edge.
    step(1'b0, 4'h7, 4'h8, 1'b0, 16'h1234, 16'h4321, 1'b0);
    chk4("b2b_pre", 5'h0F);
    chk16("b2b_pre16", 17'h05555);
    step(1'b1, 4'h3, 4'h4, 1'b1, 16'h8000, 16'h8000, 1'b0);
    chk4("b2b_rst", 5'h00);
    chk16("b2b_rst16", 17'h0);
    step(1'b0, 4'hC, 4'h5, 1'b0, 16'h8000, 16'h8000, 1'b1);
    chk4("b2b_post", ref4(4'hC, 4'h5, 1'b0));
    chk16("b2b_post16", 17'h10001);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;
    test_reset();
    test_directed();
    test_exhaustive();
    test_random16();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/carry_select_adder.md
Name: carry_select_adder

Overview:
- Parameterised carry-select adder: sum = a + b + cin, with the result registered on the single system clock.
- The operand width is split into fixed-size blocks. Block 0 ripples from cin. Every later block precomputes its sum for both carry-in values (0 and 1) and muxes on the carry from the previous block.
- Used as a low-latency arithmetic primitive in datapaths. Default configuration is 4 bits wide.

Parameters:
- WIDTH, 4, operand and sum width in bits; must be at least 1.
- BLOCK, 2, bits per carry-select block; 1 ≤ BLOCK ≤ WIDTH. The last block is WIDTH mod BLOCK bits wide when BLOCK does not divide WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a    input  WIDTH  operand A, unsigned.
- b    input  WIDTH  operand B, unsigned.
- cin  input  1  carry in.
- sum  output WIDTH  registered sum, bits [WIDTH-1:0] of a+b+cin.
- cout output 1  registered carry out, bit WIDTH of a+b+cin.

Behaviour:
- One clock; rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset: rst=1 at a rising edge sets sum=0 and cout=0 at that edge. rst takes priority over any input value.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on sum/cout after edge N; no valid/ready handshake.
- Outputs hold their value between edges. A new addition can be issued every cycle (throughput 1/cycle).
- Arithmetic: {cout,sum} = a + b + cin, computed at WIDTH+1 bits, unsigned. Overflow is reported only through cout; there is no wrap flag.
- Block 0 structure: plain ripple-carry of bits [BLOCK-1:0] with carry-in = cin.
- Block k>0 structure:
  - Two ripple-carry instances with carry-in fixed at 0 and at 1.
  - The carry out of block k-1 selects both the block's sum bits and its carry out through a 2:1 mux.
  - Carry out of the final block is cout.
- The combinational path is pure logic with no latches. The result must match a behavioural a+b+cin for all inputs.
- Boundary cases:
  - All-ones + all-ones + 1 gives sum = all-ones, cout=1.
  - All-zero + cin=1 gives sum=1, cout=0.
  - When BLOCK=WIDTH the design degenerates to a single ripple block, which is legal.
- Reset mid-stream: the cycle after rst deasserts shows the result of the inputs sampled on that first non-reset edge. No pipeline contents survive reset.
- X or Z on the inputs needs no special handling.

Decomposition:
- No shared package required. A localparam NBLK = ceil(WIDTH/BLOCK) is computed locally.
- One natural sub-module, ripple_carry_block, parameterised by width N:
  - Inputs: a[N-1:0], b[N-1:0], ci.
  - Outputs: s[N-1:0], co.
  - Built from a generate loop of full adders.
- The top instantiates ripple_carry_block in a generate loop, plus the select muxes and the output register.

Test Plan:
- Reset: hold rst=1 for 2 cycles with a=1111, b=1111, cin=1 -> sum=0000, cout=0 throughout. After release, the next edge gives sum=1111, cout=1.
- a=1001, b=0110, cin=0 -> one cycle later sum=1111, cout=0.
- a=0110, b=0110, cin=1 -> sum=1101, cout=0.
- a=1001, b=1010, cin=0 -> sum=0011, cout=1.
- a=0110, b=1001, cin=1 -> sum=0000, cout=1. This is a full carry chain across every block boundary.
- Exhaustive sweep over all 512 combinations of a, b and cin at WIDTH=4 for BLOCK=1, 2, 3 and 4, applied back-to-back at one per cycle -> every result matches a+b+cin one cycle later. Repeat with random inputs at WIDTH=16, BLOCK=4.
